// File: rtl/btb_update_ctrl.sv
// BTB update controller: classifies resolved branches, queues BTB writes in order,
// and produces the registered front-end redirect plus a saturating mispredict count.
module btb_update_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [31:0] res_pc,
    input  logic [31:0] res_target,
    input  logic        res_taken,
    input  logic        pred_hit,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    input  logic [1:0]  pred_idx,
    output logic        upd_valid,
    input  logic        upd_ready,
    output logic        upd_alloc,
    output logic        upd_retarget,
    output logic        upd_clear,
    output logic [31:0] upd_pc,
    output logic [31:0] upd_target,
    output logic [1:0]  upd_idx,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] mispredict_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_ALLOC,
        KIND_RETARGET,
        KIND_CLEAR
    } kind_e;

    // Queue storage is not reset: every read is qualified by a non-zero count.
    kind_e       kind_mem_q [DEPTH];
    logic [31:0] pc_mem_q   [DEPTH];
    logic [31:0] tgt_mem_q  [DEPTH];
    logic [1:0]  idx_mem_q  [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          redirect_valid_q, redirect_valid_d;
    logic [31:0]   redirect_pc_q, redirect_pc_d;
    logic [31:0]   mis_cnt_q, mis_cnt_d;

    kind_e       res_kind;
    logic [31:0] res_pc_plus4;
    logic [31:0] enq_target;
    logic        accept;
    logic        enq;
    logic        deq;
    logic        mispredict;
    kind_e       head_kind;

    assign res_pc_plus4 = res_pc + 32'd4;
    assign res_ready    = (count_q != CW'(DEPTH));
    assign accept       = res_valid && res_ready;

    always_comb begin
        res_kind = KIND_NONE;
        if (res_taken && !pred_hit) begin
            res_kind = KIND_ALLOC;
        end else if (res_taken && (!pred_taken || (pred_target != res_target))) begin
            res_kind = KIND_RETARGET;
        end else if (!res_taken && pred_hit && pred_taken) begin
            res_kind = KIND_CLEAR;
        end
    end

    assign mispredict = (res_taken && (pred_target != res_target)) ||
                        (!res_taken && (pred_target != res_pc_plus4));
    assign enq_target = (res_kind == KIND_CLEAR) ? res_pc_plus4 : res_target;
    assign enq        = accept && (res_kind != KIND_NONE);
    // A write is never offered during the reset cycle, even if entries are still queued.
    assign upd_valid  = (count_q != '0) && !rst;
    assign deq        = upd_valid && upd_ready;

    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        redirect_valid_d = accept && mispredict;
        redirect_pc_d    = redirect_pc_q;
        mis_cnt_d        = mis_cnt_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (accept && mispredict) begin
            redirect_pc_d = res_taken ? res_target : res_pc_plus4;
            if (mis_cnt_q != 32'hFFFF_FFFF) begin
                mis_cnt_d = mis_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            mis_cnt_q        <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            mis_cnt_q        <= mis_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            kind_mem_q[wr_ptr_q] <= res_kind;
            pc_mem_q[wr_ptr_q]   <= res_pc;
            tgt_mem_q[wr_ptr_q]  <= enq_target;
            idx_mem_q[wr_ptr_q]  <= pred_idx;
        end
    end

    assign head_kind        = kind_mem_q[rd_ptr_q];
    assign upd_alloc        = upd_valid && (head_kind == KIND_ALLOC);
    assign upd_retarget     = upd_valid && (head_kind == KIND_RETARGET);
    assign upd_clear        = upd_valid && (head_kind == KIND_CLEAR);
    assign upd_pc           = upd_valid ? pc_mem_q[rd_ptr_q]  : '0;
    assign upd_target       = upd_valid ? tgt_mem_q[rd_ptr_q] : '0;
    assign upd_idx          = upd_valid ? idx_mem_q[rd_ptr_q] : '0;
    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign mispredict_count = mis_cnt_q;
endmodule

// File: doc/btb_update_ctrl.md
# btb_update_ctrl

Branch-resolution controller that sequences all writes into the 4-entry branch target buffer. It sits between the execute stage and the BTB write port. It classifies each resolved branch as allocate, retarget, clear or no-op, and buffers pending writes in a 4-deep in-order queue. It drains the queue one write per cycle when the BTB accepts. It also produces the registered front-end redirect on a misprediction and counts mispredictions.

## Interface
- DEPTH, 4, update queue entries (power of two, ≥2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- res_valid  in  1  execute stage presents a resolved branch/jump this cycle
- res_ready  out  1  controller can accept a resolution; equals !full
- res_pc  in  32  PC of resolved instruction
- res_target  in  32  computed target address
- res_taken  in  1  actual direction
- pred_hit  in  1  BTB hit recorded at fetch
- pred_taken  in  1  direction predicted at fetch
- pred_target  in  32  address fetched after the instruction
- pred_idx  in  2  BTB way recorded at fetch
- upd_valid  out  1  head of queue is presented to BTB
- upd_ready  in  1  BTB write port free this cycle
- upd_alloc  out  1  write to PLRU replacement way
- upd_retarget  out  1  write to way upd_idx, taken target
- upd_clear  out  1  write to way upd_idx, not-taken fix
- upd_pc, upd_target  out  32 each  entry contents
- upd_idx  out  2  way for retarget/clear
- redirect_valid  out  1  one-cycle front-end redirect pulse
- redirect_pc  out  32  corrected fetch address
- mispredict_count  out  32  saturating misprediction counter

## Operation
- A resolution is accepted when res_valid && res_ready, and is classified as follows:
  - ALLOC: res_taken && !pred_hit.
  - RETARGET: res_taken && pred_hit && (!pred_taken || pred_target != res_target).
  - CLEAR: !res_taken && pred_hit && pred_taken.
  - NONE: all other cases.
- Exactly one of upd_alloc, upd_retarget and upd_clear is high whenever upd_valid is high. All three are low when upd_valid is low.
- ALLOC, RETARGET and CLEAR are enqueued as {kind, pc, target, idx}. NONE is not enqueued.
- For CLEAR, the stored target is res_pc+4.
- Misprediction occurs when (res_taken && pred_target != res_target) || (!res_taken && pred_target != res_pc+4).
  - On a misprediction the controller registers redirect_pc = res_taken ? res_target : res_pc+4.
  - It also increments mispredict_count, saturating at 32'hFFFF_FFFF.
- The queue is a circular buffer with wr_ptr, rd_ptr and an occupancy counter of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Dequeue occurs when upd_valid && upd_ready. Entries drain strictly in order. No coalescing of duplicate PCs.
- Simultaneous enqueue and dequeue leaves the count unchanged and moves both pointers.
- Full: res_ready=0. A dequeue in the same cycle does not raise res_ready combinationally.
- Empty: upd_valid=0. A newly enqueued entry is not bypassed to the output.
- Redirects are never blocked by queue state, but are only produced for accepted resolutions.
- Reset:
  - pointers, count and mispredict_count are 0; redirect_valid=0; redirect_pc=0; upd_* outputs are 0.
  - res_ready=1 after reset.
  - Reset mid-drain discards all queued entries. No write is issued in the reset cycle.

## Timing
- Accepted resolution at edge N:
  - the entry is visible on upd_* from cycle N+1;
  - redirect_valid is high for exactly cycle N+1;
  - mispredict_count is updated at edge N.
- Back-to-back accepted mispredictions give redirect_valid high on consecutive cycles, each carrying its own redirect_pc.
- Throughput is one enqueue and one dequeue per cycle. Latency from resolution to BTB write is at least 1 cycle, plus the number of cycles upd_ready is low.
- upd_* outputs are held stable while upd_valid && !upd_ready.
- All outputs are driven from registers or from queue storage. There is no combinational path from res_* to any output except through res_ready (which depends on state only).

## Test plan
- Reset, then res_valid with pc=0x100, target=0x200, taken=1, pred_hit=0, pred_target=0x104, upd_ready=1.
  - Next cycle: upd_valid=1, upd_alloc=1, upd_pc=0x100, upd_target=0x200; redirect_valid=1, redirect_pc=0x200; count=1.
- pred_hit=1, pred_idx=2, pred_taken=1, pred_target=0x200, res_taken=0, pc=0x100.
  - Response: upd_clear=1, upd_idx=2, upd_target=0x104; redirect_pc=0x104.
- Correct prediction: taken, hit, pred_target=res_target=0x300.
  - Response: no enqueue, no redirect, count unchanged.
- Hold upd_ready=0 and issue 5 ALLOC resolutions on consecutive cycles.
  - Response: 4 accepted, res_ready=0 on the cycle after the 4th acceptance. Outputs stay stable.
  - Raise upd_ready: entries drain in order, one per cycle, then res_ready=1.
- Full queue with simultaneous dequeue and res_valid.
  - Response: the resolution is not accepted that cycle (res_ready=0); count becomes 3.
- Assert rst while 3 entries are queued.
  - Response: next cycle upd_valid=0, res_ready=1, mispredict_count=0, redirect_valid=0.
